// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
// Carries Z only when SEQ_CHUNK_ADDER_ZERO_FLAG_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;
`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
    logic             Z;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf, Z
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf, Z
    );
`else
    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry kept in a flop.
// Optional zero flag output Z enabled by SEQ_CHUNK_ADDER_ZERO_FLAG_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [NCHUNK-1:0][CHUNK-1:0] vec_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    vec_t             a_r;
    vec_t             b_r;
    vec_t             s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             rdy_r;
    logic             vld_r;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   sum;
    logic             c_msb;
    logic             c_zero;

    always_comb begin
        a_c    = a_r[idx];
        b_c    = b_r[idx];
        sum    = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
        // carry into the top bit of this slice, recovered from the sum bit
        c_msb  = sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
        c_zero = (sum[CHUNK-1:0] == '0);
    end

`ifdef SEQ_CHUNK_ADDER_ZERO_FLAG_EN
    logic zacc;
    logic z_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zacc <= 1'b0;
            z_r  <= 1'b0;
        end else begin
            if (state == IDLE && bus.in_valid && rdy_r) begin
                zacc <= 1'b1;
            end else if (state == RUN) begin
                zacc <= zacc & c_zero;
                if (idx == LAST) begin
                    z_r <= zacc & c_zero;
                end
            end
        end
    end

    assign bus.Z = z_r;
`else
    logic unused_zero;
    assign unused_zero = c_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            rdy_r  <= 1'b1;
            vld_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && rdy_r) begin
                        a_r   <= bus.A;
                        b_r   <= bus.Sub ? ~bus.B : bus.B;
                        carry <= bus.Cin ^ bus.Sub;
                        idx   <= '0;
                        rdy_r <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_r[idx] <= sum[CHUNK-1:0];
                    carry    <= sum[CHUNK];
                    if (idx == LAST) begin
                        cout_r <= sum[CHUNK];
                        ovf_r  <= c_msb ^ sum[CHUNK];
                        idx    <= '0;
                        vld_r  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld_r <= 1'b0;
                        rdy_r <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld_r <= 1'b0;
                    rdy_r <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy_r;
    assign bus.out_valid = vld_r;
    assign bus.S         = s_r;
    assign bus.Cout      = cout_r;
    assign bus.Ovf       = ovf_r;
endmodule
